bit_shift_adder_core: RTL and testbench
=======================================

# bit_shift_adder_core

Bit-serial adder for the RSA datapath. It loads two DATA_WIDTH-bit operands in parallel, then adds them one bit per enabled clock cycle, LSB first, with a registered carry. The sum leaves as a serial bit stream on `a_i`, which feeds the downstream bit-serial Montgomery multiplier stage.

## Interface
Parameters:
- DATA_WIDTH, default 8: operand width in bits; must be ≥ 2.

Ports:
- clk  input  1: the one clock; all state changes on its rising edge.
- rst  input  1: synchronous, active-high reset.
- ce  input  1: clock enable; when 0, all state holds, except that rst still takes effect.
- en  input  1: step enable; when 1 (with ce=1), one serial add step runs per cycle.
- load  input  1: parallel load of a0 and a1; starts a new addition.
- a0  input  DATA_WIDTH: operand 0.
- a1  input  DATA_WIDTH: operand 1.
- a_i  output  1: registered serial sum bit, LSB first.

## Operation
- Internal state:
  - Shift registers sh0 and sh1, each DATA_WIDTH bits.
  - carry register, 1 bit.
  - Step counter cnt.
  - busy flag.
  - Output register a_i.
- Priority on each rising edge: rst > (ce=0 hold) > load > step > idle.
- rst=1: sh0, sh1, carry, cnt, busy and a_i all clear to 0.
- load=1 with ce=1:
  - sh0 ← a0 and sh1 ← a1.
  - carry ← 0, cnt ← 0, busy ← 1, a_i ← 0.
  - en is ignored in the load cycle.
- Step (ce=1, en=1, busy=1, load=0):
  - a_i ← sh0[0] ^ sh1[0] ^ carry.
  - carry ← majority(sh0[0], sh1[0], carry).
  - sh0 and sh1 each shift right one bit, with 0 entering at the MSB.
  - cnt increments.
- When the last step completes (cnt reaches TOTAL−1), busy ← 0.
  - TOTAL = DATA_WIDTH, or DATA_WIDTH+1 (see Configuration).
- Idle (busy=0, ce=1, load=0): a_i ← 0 and all other state holds.
- en=0 with busy=1: all state holds (pause) and a_i keeps its last value.
- Reload while busy: the in-progress addition is abandoned and the new operands start from step 0.
- Arithmetic: the serial stream is the modulo-2^TOTAL sum of a0 and a1.
  - Overflow beyond the DATA_WIDTH bits is visible only through the carry-out bit, when that bit is enabled.

## Timing
- Reset value of a_i is 0.
- Load at edge k.
- With en held at 1, sum bit j appears on a_i after edge k+1+j and is valid for that whole cycle.
- The last bit appears after edge k+TOTAL; a_i returns to 0 one enabled cycle later.
- Each cycle with ce=0, or with en=0 while busy, delays every later bit by one cycle.
- No handshake or valid flag: the consumer counts cycles from load.

## Configuration
- Macro BIT_SHIFT_ADDER_CARRY_OUT_EN.
- Defined: TOTAL = DATA_WIDTH+1. The final step outputs the carry-out; sh0 and sh1 are all zero by then, so the normal step equation yields the carry naturally.
- Undefined: TOTAL = DATA_WIDTH. The carry is dropped and busy clears after DATA_WIDTH steps.

## Structure
- Package bit_shift_adder_pkg holds:
  - function cnt_width(w) = $clog2(w+2).
  - localparam-style helper for TOTAL, selected by the macro.
- One sub-module, full_adder_cell: combinational; inputs a, b, cin; outputs s, cout. Used for the step equations.
- The top level holds the registers, the counter and the control logic.

## Test plan
- Reset, then load a0=0x5B, a1=0x2A with en=1:
  - a_i sequence 1,0,1,0,0,0,0,1 (0x85 LSB first).
  - With the macro defined, a 9th bit of 0 follows.
  - Then a_i=0.
- Load a0=0xFF, a1=0x01:
  - Eight 0s.
  - With the macro defined, a 9th bit of 1 follows; without it, a_i=0 after the 8th bit.
- Pause mid-stream:
  - Same operands as the first scenario; drop en for 3 cycles after bit 2.
  - a_i holds at 1 during the pause, then the sequence resumes unchanged.
  - Repeat with ce=0 for 3 cycles: identical result.
- rst pulse after bit 3:
  - a_i=0 on the next cycle and stays 0.
  - A later load runs normally.
- Reload mid-stream:
  - Load 0x5B/0x2A; after bit 4, load a0=0x03, a1=0x01 with en=1.
  - Stream restarts as 0,0,1,0,0,0,0,0 (0x04).

Source files
------------

// File: rtl/bit_shift_adder_pkg.sv
// Shared helpers for the bit-serial adder: counter sizing and step count.
// BIT_SHIFT_ADDER_CARRY_OUT_EN adds one extra step that emits the carry-out.
package bit_shift_adder_pkg;

    // Wide enough to count up to width+1 steps
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

    // Number of serial steps per addition
    function automatic int total_steps(input int w);
`ifdef BIT_SHIFT_ADDER_CARRY_OUT_EN
        return w + 1;
`else
        return w;
`endif
    endfunction

`ifdef BIT_SHIFT_ADDER_CARRY_OUT_EN
    localparam bit CARRY_OUT_EN = 1'b1;
`else
    localparam bit CARRY_OUT_EN = 1'b0;
`endif

endpackage

// File: rtl/bit_shift_adder_core_full_adder_cell.sv
// Single-bit full adder used for the serial step equations.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_shift_adder_core.sv
// Bit-serial adder: parallel load, then one LSB-first sum bit per enabled step.
// Defining BIT_SHIFT_ADDER_CARRY_OUT_EN appends the carry-out as a final bit.
module bit_shift_adder_core
    import bit_shift_adder_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  en,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] a0,
    input  logic [DATA_WIDTH-1:0] a1,
    output logic                  a_i
);

    localparam int TOTAL = total_steps(DATA_WIDTH);
    localparam int CW    = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - 1);

    logic [DATA_WIDTH-1:0] sh0_q, sh0_d;
    logic [DATA_WIDTH-1:0] sh1_q, sh1_d;
    logic                  carry_q, carry_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  out_q, out_d;

    logic sum_bit;
    logic carry_next;

    full_adder_cell u_fa (
        .a    (sh0_q[0]),
        .b    (sh1_q[0]),
        .cin  (carry_q),
        .s    (sum_bit),
        .cout (carry_next)
    );

    // Load beats step; idle forces the output low, a paused step holds everything.
    always_comb begin
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        out_d   = out_q;
        if (load) begin
            sh0_d   = a0;
            sh1_d   = a1;
            carry_d = 1'b0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            out_d   = 1'b0;
        end else if (busy_q) begin
            if (en) begin
                out_d   = sum_bit;
                carry_d = carry_next;
                sh0_d   = {1'b0, sh0_q[DATA_WIDTH-1:1]};
                sh1_d   = {1'b0, sh1_q[DATA_WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    busy_d = 1'b0;
                end
            end
        end else begin
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh0_q   <= '0;
            sh1_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            out_q   <= 1'b0;
        end else if (ce) begin
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
        end
    end

    assign a_i = out_q;

endmodule

// File: tb/tb_bit_shift_adder_core.sv
// Self-checking bench for bit_shift_adder_core: directed scenarios plus random
// stimulus against an arithmetic reference model (a0+a1 streamed LSB first).
module tb_bit_shift_adder_core;

    localparam int W = 8;
`ifdef BIT_SHIFT_ADDER_CARRY_OUT_EN
    localparam int TOTAL = W + 1;
`else
    localparam int TOTAL = W;
`endif

    logic         clk;
    logic         rst;
    logic         ce;
    logic         en;
    logic         load;
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic         a_i;

    int total;
    int bad;

    // Reference model state
    logic [W:0] m_sum;
    int         m_idx;
    bit         m_active;
    logic       m_out;

    bit_shift_adder_core #(.DATA_WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .en   (en),
        .load (load),
        .a0   (a0),
        .a1   (a1),
        .a_i  (a_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare after it.
    task automatic cyc(input logic r, input logic c, input logic e, input logic l,
                       input logic [W-1:0] x0, input logic [W-1:0] x1);
        rst = r; ce = c; en = e; load = l; a0 = x0; a1 = x1;
        @(posedge clk);
        if (r) begin
            m_out = 1'b0; m_active = 0; m_idx = 0;
        end else if (c) begin
            if (l) begin
                m_sum    = {1'b0, x0} + {1'b0, x1};
                m_idx    = 0;
                m_active = 1;
                m_out    = 1'b0;
                $display("txn load a0=%02h a1=%02h sum=%03h", x0, x1, m_sum);
            end else if (m_active) begin
                if (e) begin
                    m_out = m_sum[m_idx];
                    m_idx++;
                    if (m_idx == TOTAL) m_active = 0;
                end
            end else begin
                m_out = 1'b0;
            end
        end
        #1;
        check_eq("a_i_model", {31'd0, a_i}, {31'd0, m_out});
    endtask

    task automatic run_bits(input int n, output logic [15:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 1, 0, W'($urandom), W'($urandom));
            v[i] = a_i;
        end
    endtask

    task automatic pause_test(input bit use_ce, input logic [15:0] exp);
        logic [15:0] v;
        logic [15:0] w;
        cyc(0, 1, 1, 1, 8'h5B, 8'h2A);
        run_bits(3, v);
        for (int i = 0; i < 3; i++) begin
            if (use_ce) cyc(0, 0, 1, 0, 8'h00, 8'h00);
            else        cyc(0, 1, 0, 0, 8'h00, 8'h00);
            check_eq(use_ce ? "ce_pause_hold" : "en_pause_hold", {31'd0, a_i}, 32'd1);
        end
        run_bits(TOTAL - 3, w);
        check_eq(use_ce ? "ce_pause_seq" : "en_pause_seq", {16'd0, v | (w << 3)}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] exp_85;
        logic [15:0] exp_ff;
        total = 0; bad = 0;
        m_sum = '0; m_idx = 0; m_active = 0; m_out = 1'b0;
        rst = 1'b1; ce = 1'b0; en = 1'b0; load = 1'b0; a0 = '0; a1 = '0;
        exp_85 = 16'h0085;
`ifdef BIT_SHIFT_ADDER_CARRY_OUT_EN
        exp_ff = 16'h0100;
`else
        exp_ff = 16'h0000;
`endif

        cyc(1, 1, 0, 0, 8'h00, 8'h00);
        cyc(1, 0, 1, 1, 8'hFF, 8'hFF);
        check_eq("reset_a_i", {31'd0, a_i}, 32'd0);

        // 0x5B + 0x2A = 0x85
        cyc(0, 1, 1, 1, 8'h5B, 8'h2A);
        check_eq("load_cycle_a_i", {31'd0, a_i}, 32'd0);
        run_bits(TOTAL, v);
        check_eq("seq_5b_2a", {16'd0, v}, {16'd0, exp_85});
        cyc(0, 1, 1, 0, 8'h00, 8'h00);
        check_eq("idle_after_5b", {31'd0, a_i}, 32'd0);

        // 0xFF + 0x01 overflows into the carry-out
        cyc(0, 1, 1, 1, 8'hFF, 8'h01);
        run_bits(TOTAL, v);
        check_eq("seq_ff_01", {16'd0, v}, {16'd0, exp_ff});
        cyc(0, 1, 1, 0, 8'h00, 8'h00);
        check_eq("idle_after_ff", {31'd0, a_i}, 32'd0);

        pause_test(1'b0, exp_85);
        pause_test(1'b1, exp_85);

        // Reset mid-stream kills the addition
        cyc(0, 1, 1, 1, 8'h5B, 8'h2A);
        run_bits(4, v);
        cyc(1, 1, 1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 0, 8'h00, 8'h00);
            check_eq("after_rst_zero", {31'd0, a_i}, 32'd0);
        end
        cyc(0, 1, 1, 1, 8'h5B, 8'h2A);
        run_bits(TOTAL, v);
        check_eq("seq_after_rst", {16'd0, v}, {16'd0, exp_85});

        // Reload while busy restarts from step 0
        cyc(0, 1, 1, 1, 8'h5B, 8'h2A);
        run_bits(5, v);
        cyc(0, 1, 1, 1, 8'h03, 8'h01);
        run_bits(TOTAL, v);
        check_eq("seq_reload", {16'd0, v}, 16'h0004);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(logic'($urandom_range(0, 99) == 0),
                logic'($urandom_range(0, 99) < 85),
                logic'($urandom_range(0, 99) < 80),
                logic'($urandom_range(0, 99) < 7),
                W'($urandom), W'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
